// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction bus and a data bus onto one single-port memory.
// Grants are combinational in IDLE; reads complete one cycle later; dbus wins unless ibus has waited MAX_DBUS_RUN grants.
module mem_port_arbiter #(
    parameter int MAX_DBUS_RUN = 4
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic [31:0] ibus_addr,
    input  logic        ibus_read,
    output logic [31:0] ibus_rdata,
    output logic [31:0] ibus_iaddr,
    output logic        ibus_wait,

    input  logic [31:0] dbus_addr,
    input  logic        dbus_read,
    input  logic        dbus_we,
    input  logic [31:0] dbus_wdata,
    input  logic [3:0]  dbus_byteen,
    output logic [31:0] dbus_rdata,
    output logic        dbus_wait,

    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byteen,
    input  logic [31:0] mem_rdata
);

    localparam int CW = $clog2(MAX_DBUS_RUN + 2);
    localparam logic [CW-1:0] RUN_MAX = CW'(MAX_DBUS_RUN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IRD  = 2'd1,
        DRD  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   run_cnt_q, run_cnt_d;
    logic [31:0]     ibus_iaddr_q, ibus_iaddr_d;
    logic [31:0]     ibus_rdata_q, ibus_rdata_d;
    logic [31:0]     dbus_rdata_q, dbus_rdata_d;

    logic            dbus_req;
    logic            run_full;
    logic            ibus_gnt;
    logic            dbus_gnt;
    logic            dbus_wr_gnt;

    always_comb begin
        dbus_req    = dbus_read | dbus_we;
        run_full    = (run_cnt_q == RUN_MAX);
        // rst_n gates issue so nothing reaches memory while reset is held
        ibus_gnt    = rst_n && (state_q == IDLE) && ibus_read && (!dbus_req || run_full);
        dbus_gnt    = rst_n && (state_q == IDLE) && dbus_req && !ibus_gnt;
        dbus_wr_gnt = dbus_gnt && dbus_we;

        mem_read    = ibus_gnt || (dbus_gnt && !dbus_we);
        mem_write   = dbus_wr_gnt;
        mem_addr    = ibus_gnt ? ibus_addr : dbus_addr;
        mem_byteen  = ibus_gnt ? 4'b1111 : dbus_byteen;
        mem_wdata   = dbus_wdata;

        ibus_wait   = ibus_read && (state_q != IRD);
        dbus_wait   = dbus_req && (state_q != DRD) && !dbus_wr_gnt;

        ibus_rdata  = (state_q == IRD) ? mem_rdata : ibus_rdata_q;
        dbus_rdata  = (state_q == DRD) ? mem_rdata : dbus_rdata_q;
        ibus_iaddr  = ibus_iaddr_q;
    end

    always_comb begin
        state_d      = IDLE;
        run_cnt_d    = run_cnt_q;
        ibus_iaddr_d = ibus_iaddr_q;
        ibus_rdata_d = ibus_rdata_q;
        dbus_rdata_d = dbus_rdata_q;

        case (state_q)
            IDLE: begin
                if (ibus_gnt) begin
                    state_d      = IRD;
                    ibus_iaddr_d = ibus_addr;
                end else if (dbus_gnt && !dbus_we) begin
                    state_d = DRD;
                end
            end
            IRD:     ibus_rdata_d = mem_rdata;
            DRD:     dbus_rdata_d = mem_rdata;
            default: state_d = IDLE;
        endcase

        // Streak only counts while ibus is actually being held off
        if (!ibus_read || ibus_gnt) begin
            run_cnt_d = '0;
        end else if (dbus_gnt && !run_full) begin
            run_cnt_d = run_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            run_cnt_q    <= '0;
            ibus_iaddr_q <= '0;
            ibus_rdata_q <= '0;
            dbus_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            run_cnt_q    <= run_cnt_d;
            ibus_iaddr_q <= ibus_iaddr_d;
            ibus_rdata_q <= ibus_rdata_d;
            dbus_rdata_q <= dbus_rdata_d;
        end
    end

endmodule
